spirsp: RTL and testbench

Card-side counterpart to the SD-card SPI command issuer. Sits above a byte-level SPI slave, which delivers MOSI bytes and shifts out MISO bytes. The block:
- frames 6-byte SD commands and checks the CRC7 and end bit;
- hands each command to the card-emulation logic;
- serializes the R1/R1b/R3/R7 response back with the required N_CR filler and busy signalling.

Used in the SD-card emulator and as the bench model for the host command path.

---
 rtl/spirsp.sv | 247 ++++++++++++++++++++++++
 tb/tb_spirsp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spirsp.sv
// spirsp: card-side SD SPI command framer and R1/R1b/R3/R7 response serializer.
// Define SPIRSP_CRC_EN to build CRC7/end-bit checking with internal CRC-error R1.
`timescale 1ns/1ps
module spirsp #(
  parameter int unsigned NCR = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs_n,
  input  logic        i_ll_stb,
  input  logic [7:0]  i_ll_byte,
  output logic [7:0]  o_ll_byte,
  output logic        o_cmd_stb,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_arg,
  output logic        o_crc_err,
  input  logic        i_rsp_stb,
  input  logic [1:0]  i_rsp_type,
  input  logic [7:0]  i_rsp_r1,
  input  logic [31:0] i_rsp_data,
  input  logic        i_card_busy,
  output logic        o_busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 6;
  localparam int unsigned ARG_W  = 32;
  localparam int unsigned HDR_W  = CMD_W + ARG_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RXCMD, S_DECODE, S_WAITRSP, S_NCR, S_R1, S_DATA, S_BUSY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [1:0]          rtype_q, rtype_d;
  logic [BYTE_W-1:0]   r1_q, r1_d;
  logic [ARG_W-1:0]    data_q, data_d;
  logic [BYTE_W-1:0]   ll_byte_d;
  logic                cmd_stb_d;
  logic [CMD_W-1:0]    cmd_d;
  logic [ARG_W-1:0]    arg_d;
  logic                crc_err_d;
  logic                busy_d;
  logic                crc_bad;
  logic [BYTE_W-1:0]   busy_byte;

`ifdef SPIRSP_CRC_EN
  logic [BYTE_W-1:0]   tail_q, tail_d;

  // CRC7, poly x^7+x^3+1, init 0, MSB first over the 40 header bits
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ msg[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc_bad = (crc7({2'b01, hdr_q}) != tail_q[7:1]) || !tail_q[0];
`else
  assign crc_bad = 1'b0;
`endif

  assign busy_byte = i_card_busy ? 8'h00 : 8'hFF;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    rtype_d   = rtype_q;
    r1_d      = r1_q;
    data_d    = data_q;
    ll_byte_d = o_ll_byte;
    cmd_stb_d = 1'b0;
    cmd_d     = o_cmd;
    arg_d     = o_cmd_arg;
    crc_err_d = o_crc_err;
`ifdef SPIRSP_CRC_EN
    tail_d    = tail_q;
`endif

    case (state_q)
      S_IDLE: begin
        ll_byte_d = 8'hFF;
        if (i_ll_stb && i_ll_byte[7:6] == 2'b01) begin
          hdr_d   = HDR_W'(i_ll_byte[5:0]);
          cnt_d   = CNT_W'(5);
          state_d = S_RXCMD;
        end
      end

      S_RXCMD: begin
        if (i_ll_stb) begin
          if (cnt_q == CNT_W'(1)) begin
`ifdef SPIRSP_CRC_EN
            tail_d  = i_ll_byte;
`endif
            state_d = S_DECODE;
          end else begin
            hdr_d = {hdr_q[HDR_W-BYTE_W-1:0], i_ll_byte};
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DECODE: begin
        crc_err_d = crc_bad;
        if (crc_bad) begin
          // rejected frame answers with an illegal-CRC R1 without bothering the card
          rtype_d = 2'b00;
          r1_d    = 8'h08;
          cnt_d   = CNT_W'(NCR);
          state_d = S_NCR;
        end else begin
          cmd_stb_d = 1'b1;
          cmd_d     = hdr_q[HDR_W-1 -: CMD_W];
          arg_d     = hdr_q[ARG_W-1:0];
          state_d   = S_WAITRSP;
        end
      end

      S_WAITRSP: begin
        ll_byte_d = 8'hFF;
        if (i_rsp_stb) begin
          rtype_d = i_rsp_type;
          r1_d    = i_rsp_r1;
          data_d  = i_rsp_data;
          cnt_d   = CNT_W'(NCR);
          state_d = S_NCR;
        end
      end

      S_NCR: begin
        if (i_ll_stb) begin
          if (cnt_q == CNT_W'(1)) begin
            ll_byte_d = r1_q;
            state_d   = S_R1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_R1: begin
        if (i_ll_stb) begin
          if (rtype_q[1]) begin
            ll_byte_d = data_q[ARG_W-1 -: BYTE_W];
            data_d    = {data_q[ARG_W-BYTE_W-1:0], 8'h00};
            cnt_d     = CNT_W'(4);
            state_d   = S_DATA;
          end else if (rtype_q[0]) begin
            ll_byte_d = busy_byte;
            state_d   = S_BUSY;
          end else begin
            ll_byte_d = 8'hFF;
            state_d   = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (i_ll_stb) begin
          if (cnt_q == CNT_W'(1)) begin
            ll_byte_d = 8'hFF;
            state_d   = S_IDLE;
          end else begin
            ll_byte_d = data_q[ARG_W-1 -: BYTE_W];
            data_d    = {data_q[ARG_W-BYTE_W-1:0], 8'h00};
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
      end

      S_BUSY: begin
        // busy ends on the first exchange that actually carried FF
        if (i_ll_stb) begin
          if (o_ll_byte == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            ll_byte_d = busy_byte;
          end
        end
      end

      default: begin
        ll_byte_d = 8'hFF;
        state_d   = S_IDLE;
      end
    endcase

    if (i_cs_n) begin
      state_d   = S_IDLE;
      ll_byte_d = 8'hFF;
      cmd_stb_d = 1'b0;
      cmd_d     = o_cmd;
      arg_d     = o_cmd_arg;
      crc_err_d = o_crc_err;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      rtype_q   <= '0;
      r1_q      <= '0;
      data_q    <= '0;
      o_ll_byte <= 8'hFF;
      o_cmd_stb <= 1'b0;
      o_cmd     <= '0;
      o_cmd_arg <= '0;
      o_crc_err <= 1'b0;
      o_busy    <= 1'b0;
`ifdef SPIRSP_CRC_EN
      tail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      rtype_q   <= rtype_d;
      r1_q      <= r1_d;
      data_q    <= data_d;
      o_ll_byte <= ll_byte_d;
      o_cmd_stb <= cmd_stb_d;
      o_cmd     <= cmd_d;
      o_cmd_arg <= arg_d;
      o_crc_err <= crc_err_d;
      o_busy    <= busy_d;
`ifdef SPIRSP_CRC_EN
      tail_q    <= tail_d;
`endif
    end
  end

endmodule

// File: tb/tb_spirsp.sv
// Self-checking bench for spirsp: directed SD command/response scenarios plus
// randomized frames and responses checked against a byte-sequence model.
`timescale 1ns/1ps
module tb_spirsp;

  localparam int unsigned NCR_T = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        ll_stb;
  logic [7:0]  ll_byte;
  logic [7:0]  o_ll_byte;
  logic        o_cmd_stb;
  logic [5:0]  o_cmd;
  logic [31:0] o_cmd_arg;
  logic        o_crc_err;
  logic        rsp_stb;
  logic [1:0]  rsp_type;
  logic [7:0]  rsp_r1;
  logic [31:0] rsp_data;
  logic        card_busy;
  logic        o_busy;

  int total = 0;
  int bad = 0;
  int nstb = 0;
  int exp_nstb = 0;

  spirsp #(.NCR(NCR_T)) dut (
    .i_clk(clk), .i_reset(rst), .i_cs_n(cs_n),
    .i_ll_stb(ll_stb), .i_ll_byte(ll_byte), .o_ll_byte(o_ll_byte),
    .o_cmd_stb(o_cmd_stb), .o_cmd(o_cmd), .o_cmd_arg(o_cmd_arg), .o_crc_err(o_crc_err),
    .i_rsp_stb(rsp_stb), .i_rsp_type(rsp_type), .i_rsp_r1(rsp_r1), .i_rsp_data(rsp_data),
    .i_card_busy(card_busy), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_cmd_stb === 1'b1) nstb <= nstb + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [7:0] crc_byte(input logic [39:0] m);
    int unsigned r;
    r = 0;
    for (int i = 39; i >= -7; i--) begin
      r = (r << 1) | ((i >= 0) ? 32'(m[i]) : 32'd0);
      if ((r & 32'h80) != 0) r = r ^ 32'h89;
    end
    return {7'(r), 1'b1};
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] c, input logic [31:0] a);
    return {2'b01, c, a, crc_byte({2'b01, c, a})};
  endfunction

  // One byte exchange: MISO and busy are what the lower layer sees at exchange start
  task automatic xchg(input logic [7:0] mosi, output logic [7:0] miso, output logic bsy);
    miso = o_ll_byte;
    bsy  = o_busy;
    repeat ($urandom_range(0, 2)) tick();
    ll_stb  = 1'b1;
    ll_byte = mosi;
    tick();
    ll_stb  = 1'b0;
    ll_byte = 8'($urandom);
    tick();
  endtask

  task automatic send_frame(input logic [47:0] f, input logic exp_stb);
    logic [7:0] m;
    logic       b;
    for (int i = 0; i < 5; i++) begin
      xchg(f[47-8*i -: 8], m, b);
      chk("frame_miso", 40'(m), 40'hFF);
      if (i == 1) chk("busy_rise", 40'(b), 40'd1);
    end
    repeat ($urandom_range(0, 2)) tick();
    ll_stb  = 1'b1;
    ll_byte = f[7:0];
    tick();
    ll_stb  = 1'b0;
    chk("stb_early", 40'(o_cmd_stb), 40'd0);
    tick();
    chk("cmd_stb", 40'(o_cmd_stb), 40'(exp_stb));
    if (exp_stb) begin
      chk("cmd", 40'(o_cmd), 40'(f[45:40]));
      chk("arg", 40'(o_cmd_arg), 40'(f[39:8]));
      chk("crc_err", 40'(o_crc_err), 40'd0);
      exp_nstb++;
    end
    tick();
    chk("stb_pulse", 40'(o_cmd_stb), 40'd0);
  endtask

  // mode 0: plain request, 1: request together with a byte exchange, 2: no request
  task automatic respond(input logic [1:0] t, input logic [7:0] r1, input logic [31:0] d,
                         input int nb, input int mode);
    logic [7:0] q_b[$];
    logic [7:0] m;
    logic       b;
    int         na;
    for (int i = 0; i < int'(NCR_T); i++) q_b.push_back(8'hFF);
    q_b.push_back(r1);
    if (t[1]) begin
      for (int i = 3; i >= 0; i--) q_b.push_back(d[8*i +: 8]);
    end else if (t[0]) begin
      repeat (nb) q_b.push_back(8'h00);
      q_b.push_back(8'hFF);
    end
    na = q_b.size();
    q_b.push_back(8'hFF);

    if (mode != 2) begin
      rsp_type = t;
      rsp_r1   = r1;
      rsp_data = d;
      rsp_stb  = 1'b1;
      m        = o_ll_byte;
      if (mode == 1) begin
        ll_stb  = 1'b1;
        ll_byte = 8'hFF;
      end
      tick();
      rsp_stb  = 1'b0;
      ll_stb   = 1'b0;
      rsp_type = 2'($urandom);
      rsp_r1   = 8'($urandom);
      rsp_data = $urandom;
      if (mode == 1) begin
        chk("simul_miso", 40'(m), 40'hFF);
        tick();
      end
    end

    for (int k = 0; k < q_b.size(); k++) begin
      if (t == 2'b01) card_busy = (k >= int'(NCR_T)) && (k < int'(NCR_T) + nb);
      else            card_busy = 1'($urandom);
      xchg(8'hFF, m, b);
      chk("miso", 40'(m), 40'(q_b[k]));
      chk("busy", 40'(b), (k < na) ? 40'd1 : 40'd0);
    end
    card_busy = 1'b0;
  endtask

  initial begin
    logic [7:0]  m;
    logic        b;
    logic [7:0]  noise [3];
    logic [47:0] f0, f8, fbad, f;
    logic [5:0]  c;
    logic [31:0] a, d;
    logic [1:0]  t;
    logic [7:0]  r1;
    logic        corrupt;
    int          nb, mode;

    rst = 1'b1; cs_n = 1'b0; ll_stb = 1'b0; ll_byte = 8'h00;
    rsp_stb = 1'b0; rsp_type = 2'b00; rsp_r1 = 8'h00; rsp_data = 32'h0; card_busy = 1'b0;
    repeat (3) tick();
    chk("rst_ll_byte", 40'(o_ll_byte), 40'hFF);
    chk("rst_cmd_stb", 40'(o_cmd_stb), 40'd0);
    chk("rst_crc_err", 40'(o_crc_err), 40'd0);
    chk("rst_busy", 40'(o_busy), 40'd0);
    chk("rst_cmd", 40'(o_cmd), 40'd0);
    chk("rst_arg", 40'(o_cmd_arg), 40'd0);
    rst = 1'b0;
    tick();

    // stray response request and non-start bytes in IDLE are ignored
    rsp_type = 2'b10; rsp_r1 = 8'h55; rsp_stb = 1'b1;
    tick();
    rsp_stb = 1'b0;
    noise[0] = 8'hFF; noise[1] = 8'h00; noise[2] = 8'hC5;
    for (int i = 0; i < 3; i++) begin
      xchg(noise[i], m, b);
      chk("idle_miso", 40'(m), 40'hFF);
      chk("idle_busy", 40'(b), 40'd0);
    end

    f0 = 48'h40_0000_0000_95;
    f8 = 48'h48_0000_01AA_87;
    chk("model_crc0", 40'(mkframe(6'd0, 32'h0)), 40'(f0));

    send_frame(f0, 1'b1);
    respond(2'b00, 8'h01, 32'h0, 0, 0);

    send_frame(f8, 1'b1);
    respond(2'b10, 8'h01, 32'h0000_01AA, 0, 0);
    chk("cmd_hold", 40'(o_cmd), 40'd8);
    chk("arg_hold", 40'(o_cmd_arg), 40'h1AA);

    fbad = 48'h40_0000_0000_97;
`ifdef SPIRSP_CRC_EN
    send_frame(fbad, 1'b0);
    respond(2'b00, 8'h08, 32'h0, 0, 2);
`else
    send_frame(fbad, 1'b1);
    respond(2'b00, 8'h01, 32'h0, 0, 1);
`endif

    send_frame(mkframe(6'd12, 32'h0), 1'b1);
    respond(2'b01, 8'h00, 32'h0, 3, 0);

    // chip select dropped mid-frame
    for (int i = 0; i < 3; i++) xchg(f0[47-8*i -: 8], m, b);
    chk("abort_busy_pre", 40'(o_busy), 40'd1);
    cs_n = 1'b1;
    tick();
    chk("abort_busy", 40'(o_busy), 40'd0);
    chk("abort_miso", 40'(o_ll_byte), 40'hFF);
    tick();
    cs_n = 1'b0;
    tick();
    send_frame(f0, 1'b1);
    respond(2'b00, 8'h01, 32'h0, 0, 0);

    // reset while the second data byte is presented
    send_frame(f8, 1'b1);
    rsp_type = 2'b10; rsp_r1 = 8'h01; rsp_data = 32'h0000_01AA; rsp_stb = 1'b1;
    tick();
    rsp_stb = 1'b0;
    xchg(8'hFF, m, b);
    chk("rd_fill", 40'(m), 40'hFF);
    xchg(8'hFF, m, b);
    chk("rd_r1", 40'(m), 40'h01);
    xchg(8'hFF, m, b);
    chk("rd_d0", 40'(m), 40'h00);
    chk("rd_busy", 40'(o_busy), 40'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_miso", 40'(o_ll_byte), 40'hFF);
    chk("rst_mid_busy", 40'(o_busy), 40'd0);
    chk("rst_mid_cmd", 40'(o_cmd), 40'd0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(f8, 1'b1);
    respond(2'b10, 8'h01, 32'h0000_01AA, 0, 0);

    for (int it = 0; it < 16; it++) begin
      c = 6'($urandom);
      a = $urandom;
      f = mkframe(c, a);
      corrupt = ($urandom_range(0, 4) == 0);
      if (corrupt) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      t    = 2'($urandom);
      r1   = {1'b0, 7'($urandom)};
      d    = $urandom;
      nb   = $urandom_range(0, 3);
      mode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        xchg(8'hFF, m, b);
        chk("rnd_idle_miso", 40'(m), 40'hFF);
      end
`ifdef SPIRSP_CRC_EN
      if (corrupt) begin
        send_frame(f, 1'b0);
        respond(2'b00, 8'h08, 32'h0, 0, 2);
      end else begin
        send_frame(f, 1'b1);
        respond(t, r1, d, nb, mode);
      end
`else
      send_frame(f, 1'b1);
      respond(t, r1, d, nb, mode);
`endif
    end

    tick();
    chk("stb_count", 40'(nstb), 40'(exp_nstb));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
